data_main_memory: RTL and testbench

- Backing store for the data cache: the next level below the cache controller, serving block refills and word writes with fixed multi-cycle latency.
- The cache holds the processor in stall while it waits on this block.
- Word-organised RAM covering the same 10-bit byte address space the core drives.
- Request/ready handshake in; burst of words out, one per cycle.

---
 rtl/data_main_memory.sv | 149 ++++++++++++++
 tb/tb_data_main_memory.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_main_memory.sv
// data_main_memory: word-organised backing store behind the data cache.
// Serves block refills (burst of BLOCK_WORDS words, ascending) and single
// word writes, each after a fixed LATENCY-cycle wait. Every output is taken
// straight from a flop.
//
// Handshake: a request is accepted on a rising edge where ready=1 and
// req_rd or req_wr is high. When both are high, the write wins. A request
// presented while ready=0 is ignored, so the requester must hold it until
// it sees ready=1 at a rising edge. rvalid qualifies rdata/word_idx for
// one cycle per word. done pulses once in the final cycle of a completed
// request and never coincides with ready=1.
module data_main_memory #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic                           req_rd,
  input  logic                           req_wr,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [DATA_W-1:0]              wdata,
  output logic                           ready,
  output logic [DATA_W-1:0]              rdata,
  output logic                           rvalid,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_idx,
  output logic                           done,
  output logic [1:0]                     state_dbg
);

  localparam int WA_W  = ADDR_W - 2;
  localparam int DEPTH = 1 << WA_W;
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [IDX_W-1:0]   bcnt_q, bcnt_n;
  logic               op_wr_q, op_wr_n;
  logic [WA_W-1:0]    addr_q, addr_n;
  logic [DATA_W-1:0]  wdata_q, wdata_n;
  logic               commit;
  logic               done_n;
  logic [WA_W-1:0]    rd_addr;
  logic               addr_lsb_unused;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Byte-lane bits of the address carry no meaning for a word memory.
  assign addr_lsb_unused = ^addr[1:0];
  assign state_dbg       = state_q;

  // Next-state logic: accept in IDLE, count the wait, then burst (reads only).
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bcnt_n  = bcnt_q;
    op_wr_n = op_wr_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_wr || req_rd) begin
          state_n = WAIT;
          cnt_n   = '0;
          op_wr_n = req_wr;
          addr_n  = addr[ADDR_W-1:2];
          wdata_n = wdata;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          cnt_n = '0;
          if (op_wr_q) begin
            state_n = IDLE;
            commit  = 1'b1;
          end else begin
            state_n = BURST;
            bcnt_n  = '0;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      BURST: begin
        if (bcnt_q == IDX_W'(BLOCK_WORDS - 1)) begin
          state_n = IDLE;
          bcnt_n  = '0;
        end else begin
          bcnt_n = bcnt_q + IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    done_n  = ((state_n == WAIT) && op_wr_n && (cnt_n == CNT_W'(LATENCY - 1))) ||
              ((state_n == BURST) && (bcnt_n == IDX_W'(BLOCK_WORDS - 1)));
    rd_addr = {addr_n[WA_W-1:IDX_W], bcnt_n};
  end

  // Control state and registered outputs; RST aborts any request in flight.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      ready    <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
      word_idx <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      bcnt_q   <= bcnt_n;
      ready    <= (state_n == IDLE);
      rvalid   <= (state_n == BURST);
      rdata    <= (state_n == BURST) ? mem[rd_addr] : '0;
      word_idx <= (state_n == BURST) ? bcnt_n : '0;
      done     <= done_n;
    end
  end

  // Request payload, only meaningful after an accept.
  always_ff @(posedge clk) begin
    op_wr_q <= op_wr_n;
    addr_q  <= addr_n;
    wdata_q <= wdata_n;
  end

  // Write commit at the end of the last wait cycle, unless reset lands on that edge.
  always_ff @(posedge clk) begin
    if (!RST && commit) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_main_memory.sv
// Bench for data_main_memory: a transaction-level reference model expands
// each accepted request into its expected per-cycle output trace, and one
// negedge process compares the DUT against that trace every cycle.
module tb_data_main_memory;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 256;

  // clock / reset
  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          req_rd = 1'b0;
  logic          req_wr = 1'b0;
  logic [AW-1:0] addr   = '0;
  logic [DW-1:0] wdata  = '0;
  logic          ready, rvalid, done;
  logic [DW-1:0] rdata;
  logic [1:0]    word_idx;
  logic [1:0]    state_dbg_unused;

  always #5 clk = ~clk;

  data_main_memory #(
    .ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .RST(rst), .req_rd(req_rd), .req_wr(req_wr),
    .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata),
    .rvalid(rvalid), .word_idx(word_idx), .done(done),
    .state_dbg(state_dbg_unused)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // reference model: memory image plus expected per-cycle output trace
  typedef struct packed {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  idx;
    logic        done;
    logic        commit;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] mem_m [DEPTH];
  logic [7:0]  cm_addr;
  logic [31:0] cm_data;
  bit          model_on = 0;

  function automatic exp_t idle_e();
    exp_t e;
    e       = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  end

  always @(posedge clk) begin
    exp_t       e;
    logic [7:0] base;
    if (rst) begin
      exp_q.delete();
      cur = idle_e();
    end else begin
      if (cur.commit) mem_m[cm_addr] = cm_data;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
      end else if (cur.ready && (req_rd || req_wr)) begin
        if (req_wr) begin
          cm_addr = addr[9:2];
          cm_data = wdata;
          for (int i = 1; i <= LAT; i++) begin
            e        = '0;
            e.done   = (i == LAT);
            e.commit = (i == LAT);
            exp_q.push_back(e);
          end
        end else begin
          base = {addr[9:4], 2'b00};
          for (int i = 1; i <= LAT; i++) exp_q.push_back(exp_t'(0));
          for (int w = 0; w < BW; w++) begin
            e        = '0;
            e.rvalid = 1'b1;
            e.rdata  = mem_m[base + 8'(w)];
            e.idx    = 2'(w);
            e.done   = (w == BW - 1);
            exp_q.push_back(e);
          end
        end
        cur = exp_q.pop_front();
      end else begin
        cur = idle_e();
      end
    end
    model_on = 1;
  end

  // scoreboard compare: every cycle, mid-period
  always @(negedge clk) begin
    if (model_on) begin
      chk("ready",    {31'd0, ready},    {31'd0, cur.ready});
      chk("rvalid",   {31'd0, rvalid},   {31'd0, cur.rvalid});
      chk("rdata",    rdata,             cur.rdata);
      chk("word_idx", {30'd0, word_idx}, {30'd0, cur.idx});
      chk("done",     {31'd0, done},     {31'd0, cur.done});
    end
  end

  // driver tasks
  task automatic do_req(input bit rd, input bit wr, input logic [9:0] a,
                        input logic [31:0] d, input bit keep_rd);
    bit ok = 0;
    req_rd = rd; req_wr = wr; addr = a; wdata = d;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (ready) ok = 1;
    end
    chk("accept", {31'd0, ok}, 32'd1);
    if (ok) begin
      @(posedge clk); #1;
    end
    req_wr = 0;
    if (!keep_rd) req_rd = 0;
  endtask

  task automatic check_wr_timing();
    int done_at = -1, ready_at = -1, rv = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (done && done_at < 0) done_at = k;
      if (ready && ready_at < 0) ready_at = k;
      if (rvalid) rv = 1;
    end
    chk("wr_done_cycle",  done_at,  LAT);
    chk("wr_ready_cycle", ready_at, LAT + 1);
    chk("wr_no_rvalid",   rv,       0);
  endtask

  task automatic get_burst(input int pulse_k, output logic [127:0] blk);
    int nw = 0, first_k = -1, done_k = -1;
    blk = '0;
    for (int k = 1; k <= 20 && done_k < 0; k++) begin
      @(negedge clk);
      if (pulse_k > 0 && k == pulse_k) begin
        req_wr = 1; addr = 10'h104; wdata = 32'hBAD0BAD0;
      end
      if (pulse_k > 0 && k == pulse_k + 1) req_wr = 0;
      if (rvalid) begin
        blk[word_idx*32 +: 32] = rdata;
        nw++;
        if (first_k < 0) first_k = k;
      end
      if (done) done_k = k;
    end
    req_wr = 0;
    chk("burst_words",   nw,      BW);
    chk("burst_first",   first_k, LAT + 1);
    chk("burst_done_at", done_k,  LAT + BW);
  endtask

  logic [127:0] blk;

  // stimulus
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset then idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready",  {31'd0, ready},  32'd1);
      chk("idle_rvalid", {31'd0, rvalid}, 32'd0);
      chk("idle_done",   {31'd0, done},   32'd0);
      chk("idle_rdata",  rdata,           32'd0);
    end
    @(posedge clk); #1;

    // fill the whole memory so the model knows every word
    for (int i = 0; i < DEPTH; i++) do_req(0, 1, 10'(i << 2), $urandom, 0);

    // write then read
    do_req(0, 1, 10'h014, 32'hDEADBEEF, 0);
    check_wr_timing();
    do_req(1, 0, 10'h01C, 32'h0, 0);
    get_burst(0, blk);
    chk("wr_rd_word1", blk[63:32], 32'hDEADBEEF);

    // simultaneous requests: write wins, held read follows immediately
    do_req(1, 1, 10'h040, 32'h12345678, 1);
    check_wr_timing();
    @(posedge clk); #1;
    req_rd = 0;
    get_burst(0, blk);
    chk("simul_word0", blk[31:0], 32'h12345678);

    // ignore while busy
    for (int i = 0; i < BW; i++) do_req(0, 1, 10'(10'h100 + 4 * i), 32'h11111111 * (i + 1), 0);
    do_req(1, 0, 10'h108, 32'h0, 0);
    get_burst(2, blk);
    chk("busy_word0", blk[31:0],   32'h11111111);
    chk("busy_word1", blk[63:32],  32'h22222222);
    chk("busy_word3", blk[127:96], 32'h44444444);
    @(posedge clk); #1;
    do_req(1, 0, 10'h100, 32'h0, 0);
    get_burst(0, blk);
    chk("busy_after_word1", blk[63:32], 32'h22222222);

    // reset mid-burst
    @(posedge clk); #1;
    do_req(1, 0, 10'h100, 32'h0, 0);
    begin
      bit hit = 0;
      for (int k = 0; k < 20 && !hit; k++) begin
        @(negedge clk);
        if (rvalid && word_idx == 2'd1) hit = 1;
      end
      chk("midburst_seen", {31'd0, hit}, 32'd1);
    end
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
    chk("abort_ready",  {31'd0, ready},  32'd1);
    chk("abort_done",   {31'd0, done},   32'd0);
    @(posedge clk); #1;
    do_req(1, 0, 10'h104, 32'h0, 0);
    get_burst(0, blk);
    chk("reread_word2", blk[95:64], 32'h33333333);

    // top of memory
    @(posedge clk); #1;
    do_req(0, 1, 10'h3FC, 32'hA5A5A5A5, 0);
    check_wr_timing();
    do_req(1, 0, 10'h3F0, 32'h0, 0);
    get_burst(0, blk);
    chk("top_word3", blk[127:96], 32'hA5A5A5A5);
    @(posedge clk); #1;
    do_req(1, 0, 10'h000, 32'h0, 0);
    get_burst(0, blk);

    // randomized traffic with occasional reset aborts
    @(posedge clk); #1;
    for (int it = 0; it < 250; it++) begin
      int op;
      op = $urandom_range(0, 2);
      do_req(op != 1, op != 0, 10'($urandom_range(0, 1023)), $urandom, 0);
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 9)) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
      end else begin
        repeat ($urandom_range(0, 8)) @(posedge clk);
        #1;
      end
    end

    repeat (12) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
